// File: rtl/datapath_ctrl.sv
// datapath_ctrl: command sequencer that converts NOP/LDI/ADDI/MVZB commands
// into register load/drive strobes and immediate operands for a small datapath.
// The strobes and immediates are decoded from the FSM state and the latched
// command registers. They never depend on the live command inputs.
// Optional build macro DATAPATH_CTRL_SINGLE_STEP_EN adds a 'step' input. With
// it, every execute-state transition waits for step=1.
module datapath_ctrl #(
   parameter int IMM_W = 8
) (
   input  logic             clock,
   input  logic             clear,
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
   input  logic             step,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [IMM_W-1:0] cmd_imm,
   output logic             busy,
   output logic             done,
   output logic             RAin,
   output logic             RBin,
   output logic             RZin,
   output logic             RAout,
   output logic             RBout,
   output logic             RZout,
   output logic [IMM_W-1:0] AddImmediate,
   output logic [IMM_W-1:0] RegisterAimmediate,
   output logic [7:0]       cmd_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EX1  = 2'd1,
      EX2  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LDI  = 2'b01,
      OP_ADDI = 2'b10,
      OP_MVZB = 2'b11
   } op_t;

   state_t           state, state_nx;
   op_t              op_q;
   logic [IMM_W-1:0] imm_q;
   logic [7:0]       count_q;
   logic             advance;

`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   assign busy      = ~cmd_ready;
   assign cmd_count = count_q;

   // State register, command latch and completion counter; clear has priority.
   // Clear overrides an in-flight done, so an aborted command never counts.
   always_ff @(posedge clock) begin
      // NOTE: every register here uses <= so all of them update from
      // pre-edge values, independent of the statement order.
      if (clear) begin
         state   <= IDLE;
         op_q    <= OP_NOP;
         imm_q   <= '0;
         count_q <= '0;
      end else begin
         state <= state_nx;
         if (cmd_ready && cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            imm_q <= cmd_imm;
         end
         if (done) count_q <= count_q + 8'd1;
      end
   end

   // Next-state and output decode from registered state and the latched command.
   always_comb begin
      // NOTE: every output gets a default first. A path that assigns
      // nothing then holds 0 and does not infer a latch.
      state_nx           = state;
      cmd_ready          = 1'b0;
      done               = 1'b0;
      RAin               = 1'b0;
      RBin               = 1'b0;
      RZin               = 1'b0;
      RAout              = 1'b0;
      RBout              = 1'b0;
      RZout              = 1'b0;
      AddImmediate       = '0;
      RegisterAimmediate = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nx = EX1;
         end
         EX1: begin
            case (op_q)
               OP_LDI: begin
                  RAin               = 1'b1;
                  RegisterAimmediate = imm_q;
               end
               OP_ADDI: begin
                  RAout        = 1'b1;
                  RZin         = 1'b1;
                  AddImmediate = imm_q;
               end
               OP_MVZB: begin
                  RZout = 1'b1;
                  RBin  = 1'b1;
               end
               default: ;
            endcase
            if (advance) begin
               // ADDI continues into EX2. All other opcodes finish here.
               if (op_q == OP_ADDI) begin
                  state_nx = EX2;
               end else begin
                  state_nx = IDLE;
                  done     = 1'b1;
               end
            end
         end
         EX2: begin
            RZout = 1'b1;
            RBin  = 1'b1;
            if (advance) begin
               state_nx = IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table-driven and scoreboard-based bench for datapath_ctrl.
// The bench supports a build with DATAPATH_CTRL_SINGLE_STEP_EN defined. That
// build adds the 'step' connection and the held-step sequence.
module tb_datapath_ctrl;

   localparam int IMM_W = 8;

   logic             clock = 1'b0;
   logic             clear;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [IMM_W-1:0] cmd_imm;
   logic             busy;
   logic             done;
   logic             RAin, RBin, RZin, RAout, RBout, RZout;
   logic [IMM_W-1:0] AddImmediate;
   logic [IMM_W-1:0] RegisterAimmediate;
   logic [7:0]       cmd_count;
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
   logic             step;
`endif

   always #5 clock = ~clock;

   datapath_ctrl #(.IMM_W(IMM_W)) dut (
      .clock              (clock),
      .clear              (clear),
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
      .step               (step),
`endif
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_op             (cmd_op),
      .cmd_imm            (cmd_imm),
      .busy               (busy),
      .done               (done),
      .RAin               (RAin),
      .RBin               (RBin),
      .RZin               (RZin),
      .RAout              (RAout),
      .RBout              (RBout),
      .RZout              (RZout),
      .AddImmediate       (AddImmediate),
      .RegisterAimmediate (RegisterAimmediate),
      .cmd_count          (cmd_count)
   );

   // Observed output snapshot. Strobe order: {RAin,RBin,RZin,RAout,RBout,RZout}.
   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       done;
      logic [5:0] strobes;
      logic [7:0] addimm;
      logic [7:0] regimm;
      logic [7:0] count;
   } obs_t;

   // One command vector: opcode, immediate, execute length, expected strobes
   // and immediates for EX1, and expected strobes for EX2.
   typedef struct {
      logic [1:0] op;
      logic [7:0] imm;
      int         ncyc;
      logic [5:0] m1;
      logic [7:0] a1;
      logic [7:0] r1;
      logic [5:0] m2;
   } vec_t;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_LDI  = 6'b100000;  // RAin
   localparam logic [5:0] S_ADD1 = 6'b001100;  // RZin, RAout
   localparam logic [5:0] S_MOVB = 6'b010001;  // RBin, RZout

   vec_t       vecs[8];
   obs_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_count;

   function automatic obs_t observe();
      return {cmd_ready, busy, done, {RAin, RBin, RZin, RAout, RBout, RZout},
              AddImmediate, RegisterAimmediate, cmd_count};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Queue the per-cycle expectations of one command, plus the IDLE cycle after it.
   task automatic push_cmd(input vec_t v);
      sb.push_back({1'b0, 1'b1, (v.ncyc == 1), v.m1, v.a1, v.r1, exp_count});
      if (v.ncyc == 2) sb.push_back({1'b0, 1'b1, 1'b1, v.m2, 8'h00, 8'h00, exp_count});
      exp_count = exp_count + 8'd1;
      sb.push_back({1'b1, 1'b0, 1'b0, S_NONE, 8'h00, 8'h00, exp_count});
   endtask

   task automatic compare_next(input string name);
      obs_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h", name, observe());
      end else begin
         e = sb.pop_front();
         check(name, 64'(observe()), 64'(e));
      end
   endtask

   initial begin
      obs_t idle0;
      int   done_seen;
      int   bad_spacing;

      idle0 = {1'b1, 1'b0, 1'b0, S_NONE, 8'h00, 8'h00, 8'h00};

      vecs[0] = '{op: 2'b01, imm: 8'h05, ncyc: 1, m1: S_LDI,  a1: 8'h00, r1: 8'h05, m2: S_NONE};
      vecs[1] = '{op: 2'b10, imm: 8'h05, ncyc: 2, m1: S_ADD1, a1: 8'h05, r1: 8'h00, m2: S_MOVB};
      vecs[2] = '{op: 2'b00, imm: 8'h77, ncyc: 1, m1: S_NONE, a1: 8'h00, r1: 8'h00, m2: S_NONE};
      vecs[3] = '{op: 2'b11, imm: 8'h3C, ncyc: 1, m1: S_MOVB, a1: 8'h00, r1: 8'h00, m2: S_NONE};
      vecs[4] = '{op: 2'b10, imm: 8'hFF, ncyc: 2, m1: S_ADD1, a1: 8'hFF, r1: 8'h00, m2: S_MOVB};
      vecs[5] = '{op: 2'b01, imm: 8'hA5, ncyc: 1, m1: S_LDI,  a1: 8'h00, r1: 8'hA5, m2: S_NONE};
      vecs[6] = '{op: 2'b10, imm: 8'h80, ncyc: 2, m1: S_ADD1, a1: 8'h80, r1: 8'h00, m2: S_MOVB};
      vecs[7] = '{op: 2'b01, imm: 8'hFF, ncyc: 1, m1: S_LDI,  a1: 8'h00, r1: 8'hFF, m2: S_NONE};

`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
      step = 1'b1;
`endif
      // Reset, with a command offered during clear that must be ignored.
      clear     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_imm   = 8'h00;
      tick();
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_imm   = 8'h5A;
      tick();
      clear     = 1'b0;
      cmd_valid = 1'b0;
      check("reset_state", 64'(observe()), 64'(idle0));
      exp_count = 8'h00;

      // Clear during ADDI EX1 aborts the command with no done and no count.
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_imm   = 8'h05;
      tick();
      check("abort_ex1", 64'(observe()),
            64'({1'b0, 1'b1, 1'b0, S_ADD1, 8'h05, 8'h00, 8'h00}));
      clear = 1'b1;
      tick();
      clear     = 1'b0;
      cmd_valid = 1'b0;
      check("abort_idle", 64'(observe()), 64'(idle0));
      tick();
      check("abort_hold", 64'(observe()), 64'(idle0));

      // Table vectors back to back. During execution, cmd_valid stays high
      // with a different op and imm, and the DUT must ignore it.
      for (int i = 0; i < 8; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = vecs[i].op;
         cmd_imm   = vecs[i].imm;
         push_cmd(vecs[i]);
         tick();
         cmd_op  = ~vecs[i].op;
         cmd_imm = ~vecs[i].imm;
         for (int c = 0; c < vecs[i].ncyc; c++) begin
            compare_next($sformatf("vec%0d_ex%0d", i, c + 1));
            tick();
         end
         compare_next($sformatf("vec%0d_idle", i));
      end
      cmd_valid = 1'b0;
      tick();
      check("table_quiet", 64'(observe()),
            64'({1'b1, 1'b0, 1'b0, S_NONE, 8'h00, 8'h00, exp_count}));

`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
      // MVZB held in EX1 for three cycles with step=0. Then step=1 gives one done.
      step      = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_imm   = 8'h33;
      tick();
      cmd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("step_hold%0d", c), 64'(observe()),
               64'({1'b0, 1'b1, 1'b0, S_MOVB, 8'h00, 8'h00, exp_count}));
         tick();
      end
      step = 1'b1;
      check("step_done", 64'(observe()),
            64'({1'b0, 1'b1, 1'b1, S_MOVB, 8'h00, 8'h00, exp_count}));
      exp_count = exp_count + 8'd1;
      tick();
      check("step_idle", 64'(observe()),
            64'({1'b1, 1'b0, 1'b0, S_NONE, 8'h00, 8'h00, exp_count}));
`endif

      // 256 back-to-back NOPs from a cleared counter: done falls on every
      // other cycle and the count wraps to 0.
      clear = 1'b1;
      tick();
      clear       = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = 2'b00;
      cmd_imm     = 8'h00;
      done_seen   = 0;
      bad_spacing = 0;
      for (int i = 1; i <= 512; i++) begin
         tick();
         if (done) done_seen++;
         if (done !== ((i % 2) == 1)) bad_spacing++;
         if (i == 510) check("nop_count_255", 64'(cmd_count), 64'(8'hFF));
      end
      check("nop_done_pulses", 64'(done_seen), 64'(256));
      check("nop_spacing_errs", 64'(bad_spacing), 64'(0));
      check("nop_wrap", 64'(observe()), 64'(idle0));
      cmd_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
